// File: rtl/arith_sequencer_if.sv
// Bundle between the arith_sequencer and its switch/datapath environment.
// op_count exists only when ARITH_SEQ_OPCOUNT_EN is defined.
interface arith_sequencer_if;
    logic       start;
    logic [3:0] x_in;
    logic [3:0] y_in;
    logic [1:0] op_in;
    logic [7:0] result_in;
    logic       addsub_ovf_in;
    logic [1:0] multdiv_ovf_in;

    logic [3:0] x_out;
    logic [3:0] y_out;
    logic [3:0] ynot_out;
    logic [7:0] z_out;
    logic [1:0] op_out;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       addsub_ovf;
    logic [1:0] multdiv_ovf;
    logic [1:0] dbg_state;
`ifdef ARITH_SEQ_OPCOUNT_EN
    logic [7:0] op_count;
`endif

    // Handshake: start is a request level; it is sampled only while busy is
    // low, and done pulses for exactly the one cycle that result is first valid.
    modport slave (
        input  start, x_in, y_in, op_in, result_in, addsub_ovf_in, multdiv_ovf_in,
        output x_out, y_out, ynot_out, z_out, op_out, busy, done,
               result, addsub_ovf, multdiv_ovf, dbg_state
`ifdef ARITH_SEQ_OPCOUNT_EN
        , output op_count
`endif
    );

    modport master (
        output start, x_in, y_in, op_in, result_in, addsub_ovf_in, multdiv_ovf_in,
        input  x_out, y_out, ynot_out, z_out, op_out, busy, done,
               result, addsub_ovf, multdiv_ovf, dbg_state
`ifdef ARITH_SEQ_OPCOUNT_EN
        , input op_count
`endif
    );
endinterface

// File: rtl/arith_sequencer.sv
// Latches operands for an external arithmetic datapath, waits SETTLE_CYCLES, then
// captures its result. Optional saturating op counter under ARITH_SEQ_OPCOUNT_EN.
module arith_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic               clk,
    input logic               reset,
    arith_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic [3:0] ynot_q, ynot_d;
    logic [7:0] z_q, z_d;
    logic [1:0] op_q, op_d;
    logic [7:0] result_q, result_d;
    logic       aovf_q, aovf_d;
    logic [1:0] movf_q, movf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            x_q      <= 4'd0;
            y_q      <= 4'd0;
            ynot_q   <= 4'd0;
            z_q      <= 8'h00;
            op_q     <= 2'd0;
            result_q <= 8'h00;
            aovf_q   <= 1'b0;
            movf_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ynot_q   <= ynot_d;
            z_q      <= z_d;
            op_q     <= op_d;
            result_q <= result_d;
            aovf_q   <= aovf_d;
            movf_q   <= movf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        ynot_d   = ynot_q;
        z_d      = z_q;
        op_d     = op_q;
        result_d = result_q;
        aovf_d   = aovf_q;
        movf_d   = movf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                x_d     = bus.x_in;
                y_d     = bus.y_in;
                ynot_d  = 4'(4'd0 - bus.y_in);
                z_d     = {bus.x_in, bus.y_in};
                op_d    = bus.op_in;
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                // Result is registered on the edge into CAPTURE so it is valid while done is high.
                if (cnt_q == 4'd0) begin
                    result_d = bus.result_in;
                    aovf_d   = bus.addsub_ovf_in;
                    movf_d   = bus.multdiv_ovf_in;
                    state_d  = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.x_out       = x_q;
    assign bus.y_out       = y_q;
    assign bus.ynot_out    = ynot_q;
    assign bus.z_out       = z_q;
    assign bus.op_out      = op_q;
    assign bus.result      = result_q;
    assign bus.addsub_ovf  = aovf_q;
    assign bus.multdiv_ovf = movf_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == CAPTURE);
    assign bus.dbg_state   = state_q;

`ifdef ARITH_SEQ_OPCOUNT_EN
    logic [7:0] opcnt_q, opcnt_d;

    always_comb begin
        opcnt_d = opcnt_q;
        if (state_q == CAPTURE && opcnt_q != 8'hFF) opcnt_d = opcnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) opcnt_q <= 8'h00;
        else       opcnt_q <= opcnt_d;
    end

    assign bus.op_count = opcnt_q;
`endif
endmodule

// File: tb/tb_arith_sequencer.sv
// Directed bench for arith_sequencer (SETTLE_CYCLES=2); op_count checks run
// only when ARITH_SEQ_OPCOUNT_EN is defined.
module tb_arith_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    arith_sequencer_if bus ();

    arith_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_operands(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op,
                                input logic [7:0] res, input logic aovf, input logic [1:0] movf);
        bus.x_in           = x;
        bus.y_in           = y;
        bus.op_in          = op;
        bus.result_in      = res;
        bus.addsub_ovf_in  = aovf;
        bus.multdiv_ovf_in = movf;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One start pulse, then observe until busy drops (bounded).
    task automatic run_op(output int lat, output int busy_n, output int done_n);
        lat    = 0;
        busy_n = 0;
        done_n = 0;
        bus.start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (lat == 0) lat = i;
            end
            if (!bus.busy && i > 1) break;
        end
    endtask

    int lat, busy_n, done_n, dones, last_done, gap_bad;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.start = 1'b0;
        set_operands(4'hF, 4'hF, 2'b11, 8'hAA, 1'b1, 2'b11);
        do_reset();

        check_eq("rst_x",    bus.x_out, 0);
        check_eq("rst_y",    bus.y_out, 0);
        check_eq("rst_ynot", bus.ynot_out, 0);
        check_eq("rst_z",    bus.z_out, 0);
        check_eq("rst_op",   bus.op_out, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_res",  bus.result, 8'h00);
        check_eq("rst_aovf", bus.addsub_ovf, 0);
        check_eq("rst_movf", bus.multdiv_ovf, 2'b00);
`ifdef ARITH_SEQ_OPCOUNT_EN
        check_eq("rst_opcnt", bus.op_count, 0);
`endif

        // Basic add: 3 + 5 = 8, done 4 cycles after start, busy for 4 cycles.
        set_operands(4'd3, 4'd5, 2'b00, 8'h08, 1'b1, 2'b10);
        run_op(lat, busy_n, done_n);
        check_eq("add_lat",   lat, 4);
        check_eq("add_busyn", busy_n, 4);
        check_eq("add_donen", done_n, 1);
        check_eq("add_res",   bus.result, 8'h08);
        check_eq("add_aovf",  bus.addsub_ovf, 1);
        check_eq("add_movf",  bus.multdiv_ovf, 2'b10);
        check_eq("add_z",     bus.z_out, 8'h35);
        check_eq("add_ynot",  bus.ynot_out, 4'hB);

        // Result held while idle even if datapath inputs move.
        set_operands(4'd1, 4'd1, 2'b10, 8'h5A, 1'b0, 2'b01);
        tick(); tick();
        check_eq("hold_res",  bus.result, 8'h08);
        check_eq("hold_aovf", bus.addsub_ovf, 1);
        check_eq("hold_x",    bus.x_out, 4'd3);

        // Subtract operands visible after LOAD; later input changes ignored.
        set_operands(4'd4, 4'd3, 2'b01, 8'h01, 1'b0, 2'b00);
        bus.start = 1'b1;
        tick();                 // LOAD
        bus.start = 1'b0;
        check_eq("sub_busy_load", bus.busy, 1);
        check_eq("sub_res_load",  bus.result, 8'h08);
        tick();                 // first SETTLE
        check_eq("sub_ynot", bus.ynot_out, 4'hD);
        check_eq("sub_z",    bus.z_out, 8'h43);
        check_eq("sub_op",   bus.op_out, 2'b01);
        set_operands(4'd9, 4'd7, 2'b11, 8'h01, 1'b0, 2'b00);
        tick();                 // second SETTLE
        check_eq("sub_x_stable",  bus.x_out, 4'd4);
        check_eq("sub_op_stable", bus.op_out, 2'b01);
        check_eq("sub_done_early", bus.done, 0);
        tick();                 // CAPTURE
        check_eq("sub_done", bus.done, 1);
        check_eq("sub_res",  bus.result, 8'h01);
        tick();
        check_eq("sub_idle", bus.busy, 0);

        // start pulsed during SETTLE is ignored.
        set_operands(4'd2, 4'd2, 2'b10, 8'h04, 1'b0, 2'b01);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check_eq("ignore_dones", dones, 1);
        check_eq("ignore_res",   bus.result, 8'h04);
        check_eq("ignore_movf",  bus.multdiv_ovf, 2'b01);

        // Two's complement corner values.
        set_operands(4'd7, 4'd0, 2'b11, 8'h00, 1'b0, 2'b00);
        run_op(lat, busy_n, done_n);
        check_eq("ynot_y0", bus.ynot_out, 4'd0);
        set_operands(4'd7, 4'd8, 2'b11, 8'h00, 1'b0, 2'b00);
        run_op(lat, busy_n, done_n);
        check_eq("ynot_y8", bus.ynot_out, 4'd8);

        // Reset mid-SETTLE aborts: no done, result keeps reset value.
        do_reset();
        set_operands(4'd6, 4'd6, 2'b10, 8'h24, 1'b1, 2'b11);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();                 // in SETTLE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_res",  bus.result, 8'h00);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check_eq("abort_dones", dones, 0);
        check_eq("abort_res2",  bus.result, 8'h00);
        check_eq("abort_aovf",  bus.addsub_ovf, 0);

        // Reset beats start.
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        check_eq("rst_prio_busy", bus.busy, 0);
        reset = 1'b0;
        bus.start = 1'b0;
        tick();

        // start held for 20 cycles: done every 5 cycles, 4 operations.
        do_reset();
        set_operands(4'd1, 4'd2, 2'b00, 8'h03, 1'b0, 2'b00);
        bus.start = 1'b1;
        dones     = 0;
        last_done = 0;
        gap_bad   = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.done) begin
                dones++;
                if (last_done != 0 && i - last_done != 5) gap_bad++;
                if (last_done == 0 && i != 4) gap_bad++;
                last_done = i;
            end
        end
        bus.start = 1'b0;
        check_eq("held_dones", dones, 4);
        check_eq("held_gaps",  gap_bad, 0);
`ifdef ARITH_SEQ_OPCOUNT_EN
        check_eq("held_opcnt", bus.op_count, 4);
`endif
        tick(); tick(); tick(); tick(); tick();
        check_eq("held_stopped", bus.busy, 0);

`ifdef ARITH_SEQ_OPCOUNT_EN
        // 300 back-to-back operations saturate the counter.
        do_reset();
        bus.start = 1'b1;
        for (int i = 0; i < 300 * 5; i++) tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("sat_opcnt", bus.op_count, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
